tl_mem_manager: RTL and testbench

Single-beat TileLink manager endpoint backed by an on-chip word array. It sits on the manager side of `tl_socket_m1`. It consumes the socket's extended-source A and C traffic and returns D responses that the socket routes back to the originating client. It serves Get, PutFullData and PutPartialData on A, and Release and ReleaseData on C. It never issues B probes or Grants.

---
 rtl/tl_mem_if.sv | 73 +++++++
 rtl/tl_mem_manager.sv | 160 ++++++++++++++++
 tb/tb_tl_mem_manager.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/tl_mem_if.sv
// TileLink A/C/D/E channel bundle between the socket and the memory manager.
interface tl_mem_if #(
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned SOURCE_W = 6,
  parameter int unsigned SINK_W   = 4
);
  logic                a_valid_i;
  logic                a_ready_o;
  logic [2:0]          a_opcode_i;
  logic [2:0]          a_param_i;
  logic [3:0]          a_size_i;
  logic [SOURCE_W-1:0] a_source_i;
  logic [ADDR_W-1:0]   a_address_i;
  logic [7:0]          a_mask_i;
  logic [DATA_W-1:0]   a_data_i;
  logic                a_corrupt_i;

  logic                c_valid_i;
  logic                c_ready_o;
  logic [2:0]          c_opcode_i;
  logic [2:0]          c_param_i;
  logic [3:0]          c_size_i;
  logic [SOURCE_W-1:0] c_source_i;
  logic [ADDR_W-1:0]   c_address_i;
  logic [DATA_W-1:0]   c_data_i;
  logic                c_corrupt_i;

  logic                d_valid_o;
  logic                d_ready_i;
  logic [2:0]          d_opcode_o;
  logic [2:0]          d_param_o;
  logic [3:0]          d_size_o;
  logic [SOURCE_W-1:0] d_source_o;
  logic [SINK_W-1:0]   d_sink_o;
  logic                d_denied_o;
  logic [DATA_W-1:0]   d_data_o;
  logic                d_corrupt_o;

  logic                e_valid_i;
  logic                e_ready_o;
  logic [SINK_W-1:0]   e_sink_i;

  // Manager side.
  modport slave (
    input  a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i, a_mask_i,
           a_data_i, a_corrupt_i,
    output a_ready_o,
    input  c_valid_i, c_opcode_i, c_param_i, c_size_i, c_source_i, c_address_i, c_data_i,
           c_corrupt_i,
    output c_ready_o,
    output d_valid_o, d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o, d_denied_o,
           d_data_o, d_corrupt_o,
    input  d_ready_i,
    input  e_valid_i, e_sink_i,
    output e_ready_o
  );

  // Client / socket side.
  modport master (
    output a_valid_i, a_opcode_i, a_param_i, a_size_i, a_source_i, a_address_i, a_mask_i,
           a_data_i, a_corrupt_i,
    input  a_ready_o,
    output c_valid_i, c_opcode_i, c_param_i, c_size_i, c_source_i, c_address_i, c_data_i,
           c_corrupt_i,
    input  c_ready_o,
    input  d_valid_o, d_opcode_o, d_param_o, d_size_o, d_source_o, d_sink_o, d_denied_o,
           d_data_o, d_corrupt_o,
    output d_ready_i,
    output e_valid_i, e_sink_i,
    input  e_ready_o
  );
endinterface

// File: rtl/tl_mem_manager.sv
// Single-beat TileLink manager backed by an on-chip word array, with one D output register.
module tl_mem_manager #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned ADDR_W    = 64,
  parameter int unsigned SOURCE_W  = 6,
  parameter int unsigned SINK_W    = 4,
  parameter int unsigned DEPTH     = 256,
  parameter logic [63:0] BASE_ADDR = 64'h0
) (
  input logic         clk,
  input logic         rst_n,
  tl_mem_if.slave     tl_io
);
  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] SpanBytes = ADDR_W'(DEPTH) << 3;

  localparam logic [2:0] OpPutFull    = 3'd0;
  localparam logic [2:0] OpPutPartial = 3'd1;
  localparam logic [2:0] OpGet        = 3'd4;
  localparam logic [2:0] OpRelease    = 3'd6;
  localparam logic [2:0] OpReleaseDat = 3'd7;
  localparam logic [2:0] OpAccessAck  = 3'd0;
  localparam logic [2:0] OpAccessAckD = 3'd1;
  localparam logic [2:0] OpReleaseAck = 3'd6;

  typedef enum logic [0:0] {StEmpty, StFull} state_e;
  state_e state_q, state_d;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [2:0]          d_opcode_q, resp_opcode;
  logic [3:0]          d_size_q, resp_size;
  logic [SOURCE_W-1:0] d_source_q, resp_source;
  logic                d_denied_q, resp_denied;
  logic [DATA_W-1:0]   d_data_q, resp_data;
  logic                d_corrupt_q, resp_corrupt;

  logic slot_free, a_fire, c_fire, c_resp, load;
  logic [ADDR_W-1:0] a_off, c_off;
  logic a_legal, c_legal;
  logic [IdxW-1:0] a_idx, c_idx;
  logic a_wr, c_wr;

  // Fields the manager has no use for; E is sunk unconditionally.
  logic unused_inputs;
  assign unused_inputs = ^{tl_io.a_param_i, tl_io.c_param_i, tl_io.e_valid_i, tl_io.e_sink_i};

  // Handshakes: C has fixed priority so releases always drain.
  always_comb begin
    slot_free       = (state_q == StEmpty) || tl_io.d_ready_i;
    tl_io.c_ready_o = slot_free;
    tl_io.a_ready_o = slot_free && !tl_io.c_valid_i;
    tl_io.e_ready_o = 1'b1;
    c_fire          = tl_io.c_valid_i && slot_free;
    a_fire          = tl_io.a_valid_i && tl_io.a_ready_o;
    // ProbeAck and other C opcodes are consumed without a reply.
    c_resp          = c_fire && (tl_io.c_opcode_i == OpRelease ||
                                 tl_io.c_opcode_i == OpReleaseDat);
    load            = a_fire || c_resp;
  end

  // Address decode and legality for both request channels.
  always_comb begin
    a_off   = tl_io.a_address_i - BASE_ADDR;
    c_off   = tl_io.c_address_i - BASE_ADDR;
    a_legal = (tl_io.a_address_i >= BASE_ADDR) && (a_off < SpanBytes) && (tl_io.a_size_i <= 4'd3);
    c_legal = (tl_io.c_address_i >= BASE_ADDR) && (c_off < SpanBytes) && (tl_io.c_size_i <= 4'd3);
    a_idx   = IdxW'(a_off >> 3);
    c_idx   = IdxW'(c_off >> 3);
    a_wr    = a_fire && a_legal && !tl_io.a_corrupt_i &&
              (tl_io.a_opcode_i == OpPutFull || tl_io.a_opcode_i == OpPutPartial);
    c_wr    = c_fire && c_legal && !tl_io.c_corrupt_i && (tl_io.c_opcode_i == OpReleaseDat);
  end

  // Build the response for whichever request is accepted this cycle.
  always_comb begin
    resp_opcode  = OpAccessAck;
    resp_size    = '0;
    resp_source  = '0;
    resp_denied  = 1'b0;
    resp_data    = '0;
    resp_corrupt = 1'b0;
    if (c_fire) begin
      resp_opcode = OpReleaseAck;
      resp_size   = tl_io.c_size_i;
      resp_source = tl_io.c_source_i;
      resp_denied = !c_legal;
    end else if (a_fire) begin
      resp_size   = tl_io.a_size_i;
      resp_source = tl_io.a_source_i;
      unique case (tl_io.a_opcode_i)
        OpGet: begin
          resp_opcode  = OpAccessAckD;
          resp_denied  = !a_legal;
          resp_corrupt = !a_legal;
          resp_data    = a_legal ? mem_q[a_idx] : '0;
        end
        OpPutFull, OpPutPartial: resp_denied = !a_legal;
        default:                 resp_denied = 1'b1;
      endcase
    end
  end

  // Output register occupancy.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull: begin
        if (load)                 state_d = StFull;
        else if (tl_io.d_ready_i) state_d = StEmpty;
      end
      default: state_d = StEmpty;
    endcase
  end

  // D register: reloads only on a new response, so a stalled beat holds stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      d_opcode_q  <= '0;
      d_size_q    <= '0;
      d_source_q  <= '0;
      d_denied_q  <= 1'b0;
      d_data_q    <= '0;
      d_corrupt_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        d_opcode_q  <= resp_opcode;
        d_size_q    <= resp_size;
        d_source_q  <= resp_source;
        d_denied_q  <= resp_denied;
        d_data_q    <= resp_data;
        d_corrupt_q <= resp_corrupt;
      end
    end
  end

  // Word array: not reset, so contents survive rst_n; writes commit at the accept edge.
  always_ff @(posedge clk) begin
    if (c_wr) begin
      mem_q[c_idx] <= tl_io.c_data_i;
    end else if (a_wr) begin
      for (int i = 0; i < 8; i++) begin
        if (tl_io.a_mask_i[i]) mem_q[a_idx][8*i +: 8] <= tl_io.a_data_i[8*i +: 8];
      end
    end
  end

  assign tl_io.d_valid_o   = (state_q == StFull);
  assign tl_io.d_opcode_o  = d_opcode_q;
  assign tl_io.d_param_o   = 3'd0;
  assign tl_io.d_size_o    = d_size_q;
  assign tl_io.d_source_o  = d_source_q;
  assign tl_io.d_sink_o    = '0;
  assign tl_io.d_denied_o  = d_denied_q;
  assign tl_io.d_data_o    = d_data_q;
  assign tl_io.d_corrupt_o = d_corrupt_q;
endmodule

// File: tb/tb_tl_mem_manager.sv
// Directed bench for tl_mem_manager with hand-computed expected responses.
module tb_tl_mem_manager;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  tl_mem_if #(.DATA_W(64), .ADDR_W(64), .SOURCE_W(6), .SINK_W(4)) tl ();

  tl_mem_manager #(
    .DATA_W(64), .ADDR_W(64), .SOURCE_W(6), .SINK_W(4), .DEPTH(256), .BASE_ADDR(64'h1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .tl_io(tl)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    tl.a_valid_i = 1'b0;
    tl.c_valid_i = 1'b0;
  endtask

  task automatic drive_a(input logic [2:0] op, input logic [5:0] src, input logic [63:0] addr,
                         input logic [7:0] mask, input logic [63:0] data);
    tl.a_valid_i   = 1'b1;
    tl.a_opcode_i  = op;
    tl.a_param_i   = 3'd0;
    tl.a_size_i    = 4'd3;
    tl.a_source_i  = src;
    tl.a_address_i = addr;
    tl.a_mask_i    = mask;
    tl.a_data_i    = data;
    tl.a_corrupt_i = 1'b0;
  endtask

  task automatic drive_c(input logic [2:0] op, input logic [5:0] src, input logic [63:0] addr,
                         input logic [63:0] data);
    tl.c_valid_i   = 1'b1;
    tl.c_opcode_i  = op;
    tl.c_param_i   = 3'd0;
    tl.c_size_i    = 4'd3;
    tl.c_source_i  = src;
    tl.c_address_i = addr;
    tl.c_data_i    = data;
    tl.c_corrupt_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_a(3'd4, 6'd0, 64'h0, 8'h00, 64'h0);
    drive_c(3'd6, 6'd0, 64'h0, 64'h0);
    idle();
    tl.d_ready_i = 1'b1;
    tl.e_valid_i = 1'b0;
    tl.e_sink_i  = '0;

    // Reset state
    #12;
    check_eq("rst_d_valid", 64'(tl.d_valid_o), 64'd0);
    check_eq("rst_d_opcode", 64'(tl.d_opcode_o), 64'd0);
    check_eq("rst_d_data", tl.d_data_o, 64'd0);
    check_eq("rst_d_source", 64'(tl.d_source_o), 64'd0);
    check_eq("rst_a_ready", 64'(tl.a_ready_o), 64'd1);
    check_eq("rst_c_ready", 64'(tl.c_ready_o), 64'd1);
    check_eq("rst_e_ready", 64'(tl.e_ready_o), 64'd1);
    rst_n = 1'b1;
    step();

    // Put then Get (back-to-back exercises read-after-write)
    drive_a(3'd0, 6'h1A, 64'h1000, 8'hFF, 64'h1122334455667788);
    step();
    check_eq("put_valid", 64'(tl.d_valid_o), 64'd1);
    check_eq("put_opcode", 64'(tl.d_opcode_o), 64'd0);
    check_eq("put_source", 64'(tl.d_source_o), 64'h1A);
    check_eq("put_denied", 64'(tl.d_denied_o), 64'd0);
    drive_a(3'd4, 6'h1A, 64'h1000, 8'hFF, 64'h0);
    step();
    check_eq("get_valid", 64'(tl.d_valid_o), 64'd1);
    check_eq("get_opcode", 64'(tl.d_opcode_o), 64'd1);
    check_eq("get_data", tl.d_data_o, 64'h1122334455667788);
    check_eq("get_corrupt", 64'(tl.d_corrupt_o), 64'd0);
    check_eq("get_size", 64'(tl.d_size_o), 64'd3);

    // Partial write, then read back
    drive_a(3'd1, 6'h02, 64'h1000, 8'h0F, 64'hAAAAAAAAAAAAAAAA);
    step();
    check_eq("pp_opcode", 64'(tl.d_opcode_o), 64'd0);
    drive_a(3'd4, 6'h02, 64'h1000, 8'hFF, 64'h0);
    step();
    check_eq("pp_get_data", tl.d_data_o, 64'h11223344AAAAAAAA);

    // Out of range: Put just past the end must not alias onto word 0
    drive_a(3'd0, 6'h07, 64'h1800, 8'hFF, 64'h0);
    step();
    check_eq("oor_put_denied", 64'(tl.d_denied_o), 64'd1);
    drive_a(3'd4, 6'h07, 64'h1800, 8'hFF, 64'h0);
    step();
    check_eq("oor_get_opcode", 64'(tl.d_opcode_o), 64'd1);
    check_eq("oor_get_denied", 64'(tl.d_denied_o), 64'd1);
    check_eq("oor_get_corrupt", 64'(tl.d_corrupt_o), 64'd1);
    check_eq("oor_get_data", tl.d_data_o, 64'd0);
    drive_a(3'd4, 6'h07, 64'h0FF8, 8'hFF, 64'h0);
    step();
    check_eq("below_base_denied", 64'(tl.d_denied_o), 64'd1);
    drive_a(3'd4, 6'h07, 64'h1000, 8'hFF, 64'h0);
    tl.a_size_i = 4'd4;
    step();
    check_eq("big_size_denied", 64'(tl.d_denied_o), 64'd1);
    drive_a(3'd4, 6'h07, 64'h1000, 8'hFF, 64'h0);
    step();
    check_eq("oor_mem_kept", tl.d_data_o, 64'h11223344AAAAAAAA);
    check_eq("oor_mem_denied", 64'(tl.d_denied_o), 64'd0);

    // Unsupported A opcode
    drive_a(3'd2, 6'h08, 64'h1000, 8'hFF, 64'h0);
    step();
    check_eq("badop_opcode", 64'(tl.d_opcode_o), 64'd0);
    check_eq("badop_denied", 64'(tl.d_denied_o), 64'd1);
    check_eq("badop_corrupt", 64'(tl.d_corrupt_o), 64'd0);

    // Backpressure: response to source 3 held while a second Get waits
    idle();
    step();
    tl.d_ready_i = 1'b0;
    drive_a(3'd4, 6'h03, 64'h1000, 8'hFF, 64'h0);
    step();
    drive_a(3'd4, 6'h04, 64'h1000, 8'hFF, 64'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_a_ready", 64'(tl.a_ready_o), 64'd0);
      check_eq("bp_c_ready", 64'(tl.c_ready_o), 64'd0);
      check_eq("bp_d_valid", 64'(tl.d_valid_o), 64'd1);
      check_eq("bp_d_source", 64'(tl.d_source_o), 64'h03);
      check_eq("bp_d_data", tl.d_data_o, 64'h11223344AAAAAAAA);
      step();
    end
    idle();
    tl.d_ready_i = 1'b1;
    step();
    check_eq("bp_drained", 64'(tl.d_valid_o), 64'd0);

    // Simultaneous A and C: C wins
    drive_a(3'd4, 6'h05, 64'h1000, 8'hFF, 64'h0);
    drive_c(3'd7, 6'h2A, 64'h1008, 64'h00000000DEADBEEF);
    #1;
    check_eq("sim_a_ready", 64'(tl.a_ready_o), 64'd0);
    step();
    check_eq("sim_c_opcode", 64'(tl.d_opcode_o), 64'd6);
    check_eq("sim_c_source", 64'(tl.d_source_o), 64'h2A);
    check_eq("sim_c_param", 64'(tl.d_param_o), 64'd0);
    tl.c_valid_i = 1'b0;
    #1;
    check_eq("sim_a_ready2", 64'(tl.a_ready_o), 64'd1);
    step();
    check_eq("sim_a_opcode", 64'(tl.d_opcode_o), 64'd1);
    check_eq("sim_a_source", 64'(tl.d_source_o), 64'h05);
    check_eq("sim_a_data", tl.d_data_o, 64'h11223344AAAAAAAA);
    drive_a(3'd4, 6'h05, 64'h1008, 8'hFF, 64'h0);
    step();
    check_eq("rel_data", tl.d_data_o, 64'h00000000DEADBEEF);

    // Release without data must not write; ProbeAck is swallowed
    idle();
    drive_c(3'd6, 6'h11, 64'h1008, 64'h0);
    step();
    check_eq("rel_opcode", 64'(tl.d_opcode_o), 64'd6);
    check_eq("rel_source", 64'(tl.d_source_o), 64'h11);
    drive_c(3'd4, 6'h12, 64'h1008, 64'h0);
    step();
    check_eq("probeack_no_resp", 64'(tl.d_valid_o), 64'd0);
    idle();
    drive_a(3'd4, 6'h13, 64'h1008, 8'hFF, 64'h0);
    step();
    check_eq("rel_no_write", tl.d_data_o, 64'h00000000DEADBEEF);

    // Reset with a response pending
    tl.d_ready_i = 1'b0;
    drive_a(3'd4, 6'h15, 64'h1000, 8'hFF, 64'h0);
    step();
    idle();
    check_eq("pre_rst_valid", 64'(tl.d_valid_o), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(tl.d_valid_o), 64'd0);
    check_eq("mid_rst_data", tl.d_data_o, 64'd0);
    check_eq("mid_rst_source", 64'(tl.d_source_o), 64'd0);
    check_eq("mid_rst_opcode", 64'(tl.d_opcode_o), 64'd0);
    step();
    rst_n = 1'b1;
    tl.d_ready_i = 1'b1;
    step();
    drive_a(3'd4, 6'h16, 64'h1008, 8'hFF, 64'h0);
    step();
    check_eq("mem_retained", tl.d_data_o, 64'h00000000DEADBEEF);
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
